// File: rtl/r2000_divider_pkg.sv
// Shared r2000 definitions used by the multiply/divide unit: datapath width,
// logic level names and the divider sequencer states.
package r2000_divider_pkg;

    // Native r2000 operand width.
    localparam int R2000_DW = 32;

    // Named logic levels for control strobes.
    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    // Divider sequencer states: wait for a request, iterate, sign-fix and publish.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/r2000_divider.sv
// Sequential restoring divider for DIV / DIVU.
// It retires one quotient bit per clock. Signed operands are reduced to
// magnitudes on entry, and the result signs are restored in a single fixup
// cycle. The results go to LO (quotient) and HI (remainder).
module r2000_divider
    import r2000_divider_pkg::*;
#(
    parameter int DW = R2000_DW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          sign_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [DW-1:0] divider_i,
    output logic [DW-1:0] quotient_o,
    output logic [DW-1:0] remainder_o,
    output logic          write_o,
    output logic          ready_o
);

    localparam int CW = $clog2(DW + 1);

    // Two's-complement negate when requested. The same helper serves operand
    // magnitude extraction and result sign fixup. The most negative value
    // maps onto itself, which gives the natural wrap for 0x80000000 / -1.
    function automatic logic [DW-1:0] neg_if(input logic [DW-1:0] v, input logic neg);
        return neg ? ((~v) + DW'(1)) : v;
    endfunction

    div_state_t    state;
    logic [DW-1:0] dvs_q;     // divisor magnitude
    logic [DW-1:0] rem_q;     // partial remainder
    logic [DW-1:0] quo_q;     // dividend bits shifting out, quotient bits shifting in
    logic [CW-1:0] cnt_q;     // remaining iterations
    logic          qneg_q;    // quotient must be negated in FIX
    logic          rneg_q;    // remainder must be negated in FIX

    // Operand signs only matter in signed mode.
    logic dvd_neg;
    logic dvs_neg;
    assign dvd_neg = sign_i & dividend_i[DW-1];
    assign dvs_neg = sign_i & divider_i[DW-1];

    // Restoring step. The partial remainder stays below the divisor, so the
    // shifted value is below twice the divisor. Because of this, bit DW of
    // the DW+1-bit difference is an exact borrow flag. With a zero divisor
    // nothing ever borrows: the quotient fills with ones and the remainder
    // collects the dividend magnitude.
    logic [DW:0] shifted;
    logic [DW:0] trial;
    logic        borrow;
    assign shifted = {rem_q, quo_q[DW-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign borrow  = trial[DW];

    // Sequencer and datapath registers; results are only touched in FIX.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            qneg_q      <= LOW;
            rneg_q      <= LOW;
            quotient_o  <= '0;
            remainder_o <= '0;
            write_o     <= LOW;
            ready_o     <= HIGH;
        end else begin
            case (state)
                IDLE: begin
                    write_o <= LOW;
                    if (start_i) begin
                        dvs_q   <= neg_if(divider_i, dvs_neg);
                        quo_q   <= neg_if(dividend_i, dvd_neg);
                        rem_q   <= '0;
                        qneg_q  <= dvd_neg ^ dvs_neg;
                        rneg_q  <= dvd_neg;
                        cnt_q   <= CW'(DW);
                        ready_o <= LOW;
                        state   <= DIV;
                    end
                end
                DIV: begin
                    rem_q <= borrow ? shifted[DW-1:0] : trial[DW-1:0];
                    quo_q <= {quo_q[DW-2:0], ~borrow};
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient_o  <= neg_if(quo_q, qneg_q);
                    remainder_o <= neg_if(rem_q, rneg_q);
                    write_o     <= HIGH;
                    ready_o     <= HIGH;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_r2000_divider.sv
// Scoreboard bench for r2000_divider. The driver issues directed divisions
// and queues the hand-computed results. The monitor pops and compares on
// every write_o pulse, including latency and the handshake relationship.
module tb_r2000_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sign;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        wr;
    logic        rdy;

    r2000_divider #(.DW(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .sign_i      (sign),
        .dividend_i  (dvd),
        .divider_i   (dvs),
        .quotient_o  (quo),
        .remainder_o (rem),
        .write_o     (wr),
        .ready_o     (rdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          t;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait (bounded) until the divider is idle. Returns at a negedge or at the current time.
    task automatic wait_ready();
        int n = 0;
        while (rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (rdy !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_ready: timeout, ready_o=%b", rdy);
        end
    endtask

    // Issue one division. When push is set, queue the expected result.
    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] eq, input logic [31:0] er,
                         input bit push);
        exp_t e;
        wait_ready();
        start = 1'b1;
        sign  = s;
        dvd   = a;
        dvs   = b;
        @(posedge clk);
        #1;
        if (push) begin
            e.q = eq; e.r = er; e.t = cyc; e.name = name;
            sb.push_back(e);
        end
        check({name, "_busy"}, {31'd0, rdy}, 32'd0);
        @(negedge clk);
        // Scramble inputs: nothing after the start edge may leak into the result.
        start = 1'b0;
        sign  = ~s;
        dvd   = $urandom;
        dvs   = $urandom;
    endtask

    // Monitor: pop and compare on each write pulse; also check its handshake shape.
    logic prev_rdy = 1'b1;
    logic prev_wr  = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && wr === 1'b1) begin
            check("write_with_ready_rise", {30'd0, rdy, prev_rdy}, 32'd2);
            check("write_single_cycle", {31'd0, prev_wr}, 32'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got q=%h r=%h expected no write", quo, rem);
            end else begin
                e = sb.pop_front();
                check({e.name, "_q"}, quo, e.q);
                check({e.name, "_r"}, rem, e.r);
                check({e.name, "_latency"}, 32'(cyc - e.t), 32'd33);
            end
        end
        prev_rdy <= rdy;
        prev_wr  <= wr;
    end

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        sign  = 1'b0;
        dvd   = '0;
        dvs   = '0;
        #1;
        check("reset_ready", {31'd0, rdy}, 32'd1);
        check("reset_write", {31'd0, wr}, 32'd0);
        check("reset_q", quo, 32'd0);
        check("reset_r", rem, 32'd0);
        #1 rst = 1'b0;

        // Start at the very first clock edge.
        issue("u_small",   32'h56,       32'h89,       1'b0, 32'h0,        32'h56,       1);
        issue("u_456_23",  32'h456,      32'h23,       1'b0, 32'h1F,       32'h19,       1);
        issue("u_big",     32'h82345678, 32'h12345678, 1'b0, 32'h7,        32'h02C5F930, 1);
        issue("u_neg5",    32'h456,      32'hFFFFFFFB, 1'b0, 32'h0,        32'h456,      1);
        issue("s_neg5",    32'h456,      32'hFFFFFFFB, 1'b1, 32'hFFFFFF22, 32'h0,        1);
        issue("s_m5_big",  32'hFFFFFFFB, 32'h12345678, 1'b1, 32'h0,        32'hFFFFFFFB, 1);
        issue("s_m7_2",    32'hFFFFFFF9, 32'h2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1);
        issue("u_div0",    32'h1234,     32'h0,        1'b0, 32'hFFFFFFFF, 32'h1234,     1);
        issue("s_m16_div0", 32'hFFFFFFF0, 32'h0,       1'b1, 32'h1,        32'hFFFFFFF0, 1);
        issue("s_min_m1",  32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0,        1);
        issue("u_equal",   32'h12345678, 32'h12345678, 1'b0, 32'h1,        32'h0,        1);

        // A second start mid-division must be ignored.
        issue("busy_start", 32'h64,      32'h7,        1'b0, 32'hE,        32'h2,        1);
        repeat (10) @(negedge clk);
        start = 1'b1; sign = 1'b1; dvd = 32'hFFFFFF00; dvs = 32'h3;
        @(negedge clk);
        start = 1'b0;
        issue("after_busy", 32'h12345678, 32'h12345678, 1'b1, 32'h1,       32'h0,        1);

        // Reset mid-division: immediate reset values, no write pulse afterwards.
        issue("aborted",    32'hFFFF,    32'h3,        1'b0, 32'h0,        32'h0,        0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", {31'd0, rdy}, 32'd1);
        check("midrst_write", {31'd0, wr}, 32'd0);
        check("midrst_q", quo, 32'd0);
        check("midrst_r", rem, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("postrst_q", quo, 32'd0);
        check("postrst_ready", {31'd0, rdy}, 32'd1);

        // The divider must still work after the abort.
        issue("post_abort", 32'h456,     32'h23,       1'b0, 32'h1F,       32'h19,       1);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/r2000_divider.md
# r2000_divider

Sequential 32-bit integer divider for the r2000 single-cycle MIPS core's multiply/divide unit. It computes quotient and remainder for DIV (signed) and DIVU (unsigned) with MIPS semantics, one quotient bit per clock. It signals completion so the core can write LO (quotient) and HI (remainder).

## Interface
Parameters:
- DW, default 32: operand and result width.

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock, rising-edge active.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start request, sampled on a rising clk_i edge.
- sign_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- dividend_i  in  DW  numerator.
- divider_i  in  DW  denominator.
- quotient_o  out  DW  quotient; LO write data.
- remainder_o  out  DW  remainder; HI write data.
- write_o  out  1  one-cycle pulse: results valid, write HI/LO.
- ready_o  out  1  1 = idle with results stable; 0 = division in progress.

## Operation
- States: IDLE, DIV, FIX.
- IDLE:
  - ready_o=1.
  - On an edge with start_i=1: latch sign_i and the operands.
  - Signed mode: store the magnitudes, plus the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
  - Clear the partial remainder, load the iteration counter with DW, and go to DIV.
- DIV (DW cycles):
  - Restoring step: shift {rem, quo} left 1.
  - Trial subtract the divisor magnitude from rem, using a DW+1-bit subtractor.
  - If there is no borrow: rem = difference and quotient LSB=1; otherwise restore and LSB=0.
  - Decrement the counter. After the last step go to FIX.
- FIX (1 cycle):
  - Signed mode: negate the quotient if the quotient sign is set, and negate the remainder if the remainder sign is set (two's complement).
  - Register the results to quotient_o/remainder_o, pulse write_o, set ready_o=1, and return to IDLE.
- Arithmetic rules:
  - Quotient truncates toward zero.
  - The remainder has the dividend's sign, and |rem| < |divisor|.
  - 0x80000000 / -1 signed gives q=0x80000000, r=0 (wraps naturally).
- Divide by zero: the same datapath yields q=all ones and r=dividend magnitude. Signed-mode sign fixup is still applied. Completes with normal latency; no exception.
- start_i while busy (ready_o=0) is ignored. Operand changes after the start edge have no effect.
- quotient_o/remainder_o change only in FIX and hold their values until the next completion.

## Timing
- Reset (any time, including mid-division) forces the following:
  - state=IDLE, ready_o=1, write_o=0.
  - quotient_o=0, remainder_o=0, counter=0.
- Start sampled at edge T: ready_o=0 from T.
- DIV iterations occupy edges T+1..T+DW.
- FIX at edge T+DW+1: results valid, write_o=1 and ready_o=1 from this edge. Total latency DW+1 = 33 cycles.
- write_o is high exactly one cycle per division.
- start_i=1 at the completion edge (T+DW+1) is not accepted. The next accepted start is at T+DW+2 at the earliest.
- Back-to-back operation: one division per DW+2 cycles maximum.

## Structure
- Shared package (r2000 defines): DW=32, HIGH/LOW constants, state enum {IDLE, DIV, FIX}.
- Single module; no sub-module required. The negate/abs helper is an inline function used for both operand conditioning and result fixup.

## Test plan
- Reset then idle: rst_i pulse -> ready_o=1, write_o=0, quotient_o=0, remainder_o=0. Start at the first edge -> ready_o low for 33 cycles, then rises.
- Unsigned basics:
  - 0x56/0x89 -> q=0, r=0x56.
  - 0x456/0x23 -> q=0x1F, r=0x19.
  - 0x82345678/0x12345678 -> q=7, r=0x02C5F930.
- Signedness:
  - 0x456/0xFFFFFFFB unsigned -> q=0, r=0x456; signed -> q=0xFFFFFF22, r=0.
  - 0xFFFFFFFB/0x12345678 signed -> q=0, r=0xFFFFFFFB.
  - 0xFFFFFFF9/2 signed -> q=0xFFFFFFFD, r=0xFFFFFFFF.
- Corner cases:
  - x/0 unsigned with x=0x1234 -> q=0xFFFFFFFF, r=0x1234.
  - 0x80000000/0xFFFFFFFF signed -> q=0x80000000, r=0.
  - 0x12345678/0x12345678 -> q=1, r=0.
- Handshake:
  - Pulse start_i again mid-division -> ignored; results unchanged, latency still 33.
  - Assert rst_i mid-division -> immediate return to reset values, no write_o pulse.
  - Check write_o is a single one-cycle pulse coincident with the rising edge of ready_o.
